inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the core's fetch port (physical PC in, instruction word and fetch stall out) and a burst-capable memory read port. Hits return the instruction in the same cycle with no stall. Misses stall fetch while a full line is refilled. Uncached (kseg1) fetches bypass the arrays with a single-word read.

---
 rtl/inst_cache_pkg.sv | 30 +++
 rtl/icache_store.sv | 55 +++++
 rtl/inst_cache.sv | 188 ++++++++++++++++++
 tb/tb_inst_cache.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: FSM states and address-field widths.
package inst_cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    REFILL,
    UNC_REQ,
    UNC_WAIT,
    DONE
  } CacheState;

  // Byte-offset bits covering one line.
  function automatic int offBits(input int lineWords);
    return $clog2(lineWords) + 2;
  endfunction

  // Word-select bits inside a line; also the width of the refill beat counter.
  function automatic int wordBits(input int lineWords);
    return $clog2(lineWords);
  endfunction

  // Tag bits left above index and offset in a 32-bit address.
  function automatic int tagBits(input int indexW, input int lineWords);
    return WORD_W - indexW - offBits(lineWords);
  endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// whole-line write, and a one-cycle flash clear of all valid bits.
module icache_store
  import inst_cache_pkg::*;
#(
  parameter int INDEX_W    = 7,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = tagBits(INDEX_W, LINE_WORDS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INDEX_W-1:0]                  rdIndex,
  output logic                                rdValid,
  output logic [TAG_W-1:0]                    rdTag,
  output logic [LINE_WORDS-1:0][WORD_W-1:0]   rdLine,
  input  logic                                wrEn,
  input  logic [INDEX_W-1:0]                  wrIndex,
  input  logic [TAG_W-1:0]                    wrTag,
  input  logic [LINE_WORDS-1:0][WORD_W-1:0]   wrLine,
  input  logic                                invAll
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]                  validBits;
  logic [TAG_W-1:0]                  tagMem  [LINES];
  logic [LINE_WORDS-1:0][WORD_W-1:0] dataMem [LINES];

  assign rdValid = validBits[rdIndex];
  assign rdTag   = tagMem[rdIndex];
  assign rdLine  = dataMem[rdIndex];

  // Valid bits: flash clear first, so a line committed in the same cycle survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validBits <= '0;
    end else begin
      if (invAll) begin
        validBits <= '0;
      end
      if (wrEn) begin
        validBits[wrIndex] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are only meaningful behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIndex]  <= wrTag;
      dataMem[wrIndex] <= wrLine;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, full-line burst
// refill on a miss, single-word bypass for uncached fetches.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_W    = 7,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_uncached,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        inv_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_len,
  input  logic        mem_addr_ok,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast
);

  localparam int OFF   = offBits(LINE_WORDS);
  localparam int CNT_W = wordBits(LINE_WORDS);
  localparam int TAG_W = tagBits(INDEX_W, LINE_WORDS);

  logic [TAG_W-1:0]   addrTag;
  logic [INDEX_W-1:0] addrIndex;
  logic [CNT_W-1:0]   addrWord;
  logic [1:0]         unusedAddrBits;

  CacheState state, nextState;

  logic [CNT_W-1:0]                  beatCnt;
  logic [LINE_WORDS-1:0][WORD_W-1:0] refillBuf;
  logic [LINE_WORDS-1:0][WORD_W-1:0] commitLine;
  logic [WORD_W-1:0]                 uncWord;
  logic                              doneUnc;

  logic                              rdValid;
  logic [TAG_W-1:0]                  rdTag;
  logic [LINE_WORDS-1:0][WORD_W-1:0] rdLine;

  logic        hit;
  logic        startReq;
  logic        lastBeat;
  logic        stallRaw;
  logic [31:0] rdataRaw;

  logic        memReq;
  logic [31:0] memAddr;
  logic [7:0]  memLen;

  assign addrTag        = cpu_addr[31:INDEX_W+OFF];
  assign addrIndex      = cpu_addr[INDEX_W+OFF-1:OFF];
  assign addrWord       = cpu_addr[OFF-1:2];
  assign unusedAddrBits = cpu_addr[1:0];

  assign hit      = cpu_en && !cpu_uncached && rdValid && (rdTag == addrTag);
  assign startReq = (state == IDLE) && cpu_en && !hit;
  assign lastBeat = (state == REFILL) && mem_rvalid && mem_rlast;

  icache_store #(
    .INDEX_W    (INDEX_W),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) store (
    .clk     (clk),
    .rst     (rst),
    .rdIndex (addrIndex),
    .rdValid (rdValid),
    .rdTag   (rdTag),
    .rdLine  (rdLine),
    .wrEn    (lastBeat),
    .wrIndex (addrIndex),
    .wrTag   (addrTag),
    .wrLine  (commitLine),
    .invAll  (inv_all)
  );

  // Line to commit on the last beat: buffered beats plus the one arriving now.
  always_comb begin
    commitLine           = refillBuf;
    commitLine[beatCnt]  = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode plus the combinational stall and fetch data.
  always_comb begin
    nextState = state;
    stallRaw  = 1'b0;
    rdataRaw  = '0;
    case (state)
      IDLE: begin
        if (cpu_en) begin
          if (cpu_uncached) begin
            stallRaw  = 1'b1;
            nextState = UNC_REQ;
          end else if (hit) begin
            rdataRaw = rdLine[addrWord];
          end else begin
            stallRaw  = 1'b1;
            nextState = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        stallRaw = 1'b1;
        if (mem_addr_ok) nextState = REFILL;
      end
      REFILL: begin
        stallRaw = 1'b1;
        if (lastBeat) nextState = DONE;
      end
      UNC_REQ: begin
        stallRaw = 1'b1;
        if (mem_addr_ok) nextState = UNC_WAIT;
      end
      UNC_WAIT: begin
        stallRaw = 1'b1;
        if (mem_rvalid) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
        rdataRaw  = doneUnc ? uncWord : refillBuf[addrWord];
      end
      default: nextState = IDLE;
    endcase
  end

  // While reset is held the core must never see a stall.
  assign cpu_stall = stallRaw & rst;
  assign cpu_rdata = rdataRaw;

  // Registered memory request, launched on leaving IDLE and dropped once accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReq  <= 1'b0;
      memAddr <= '0;
      memLen  <= '0;
    end else if (startReq) begin
      memReq  <= 1'b1;
      memAddr <= cpu_uncached ? cpu_addr : {cpu_addr[31:OFF], {OFF{1'b0}}};
      memLen  <= cpu_uncached ? 8'd0 : 8'(LINE_WORDS - 1);
    end else if (((state == MISS_REQ) || (state == UNC_REQ)) && mem_addr_ok) begin
      memReq <= 1'b0;
    end
  end

  assign mem_req  = memReq;
  assign mem_addr = memAddr;
  assign mem_len  = memLen;

  // Refill buffer fills from word 0 upward; uncached word latched for the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beatCnt   <= '0;
      refillBuf <= '0;
      uncWord   <= '0;
      doneUnc   <= 1'b0;
    end else begin
      if ((state == MISS_REQ) && mem_addr_ok) begin
        beatCnt <= '0;
      end else if ((state == REFILL) && mem_rvalid) begin
        refillBuf[beatCnt] <= mem_rdata;
        beatCnt            <= beatCnt + 1'b1;
      end
      if ((state == UNC_WAIT) && mem_rvalid) begin
        uncWord <= mem_rdata;
      end
      if (startReq) begin
        doneUnc <= cpu_uncached;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches
// against a line-level valid/tag model and an address-hashed memory image.
module tb_inst_cache;

  localparam int INDEX_W    = 7;
  localparam int LINE_WORDS = 4;
  localparam int LINES      = 1 << INDEX_W;
  localparam int MISS_STALL = LINE_WORDS + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_uncached = 1'b0;
  logic        inv_all = 1'b0;
  logic        mem_addr_ok = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rlast = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;

  int total = 0;
  int bad   = 0;

  bit          refValid [LINES];
  int unsigned refTag   [LINES];

  always #5 clk = ~clk;

  inst_cache #(.INDEX_W(INDEX_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_addr     (cpu_addr),
    .cpu_uncached (cpu_uncached),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .inv_all      (inv_all),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_len      (mem_len),
    .mem_addr_ok  (mem_addr_ok),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_rlast    (mem_rlast)
  );

  // Memory image: test-plan words at fixed addresses, a bijective hash elsewhere.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a[31:4] == 28'h1FC0000) return 32'h11 * (32'(a[3:2]) + 32'd1);
    if (a == 32'hBFC0_0004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: decides hit/miss from line valid+tag and predicts the fetch outcome.
  task automatic modelFetch(input logic [31:0] a, input bit unc, input int okDelay, input bit invAtLast,
                            output int expStalls, output logic [31:0] expData,
                            output logic [31:0] expAddr, output logic [7:0] expLen, output bit expMiss);
    int idx;
    int unsigned tag;
    idx     = int'((a / 16) % LINES);
    tag     = a / 2048;
    expData = memData(a);
    if (unc) begin
      expStalls = 3 + okDelay;
      expAddr   = a;
      expLen    = 8'd0;
      expMiss   = 1'b1;
    end else if (refValid[idx] && refTag[idx] == tag) begin
      expStalls = 0;
      expAddr   = '0;
      expLen    = 8'd0;
      expMiss   = 1'b0;
    end else begin
      expStalls = MISS_STALL + okDelay;
      expAddr   = a - (a % 16);
      expLen    = 8'(LINE_WORDS - 1);
      expMiss   = 1'b1;
      if (invAtLast) foreach (refValid[i]) refValid[i] = 1'b0;
      refValid[idx] = 1'b1;
      refTag[idx]   = tag;
    end
  endtask

  // Drives one fetch and plays the memory side until the stall drops.
  task automatic applyStimulus(input logic [31:0] a, input bit unc, input int okDelay, input bit invAtLast,
                               output int stalls, output logic [31:0] rdata,
                               output logic [31:0] reqAddr, output logic [7:0] reqLen,
                               output int reqCycles, output bit addrStable, output bit timedOut);
    int beat;
    bit accepted;
    stalls = 0; rdata = '0; reqAddr = '0; reqLen = '0; reqCycles = 0;
    addrStable = 1'b1; timedOut = 1'b1; beat = 0; accepted = 1'b0;
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = a; cpu_uncached = unc;
    for (int cyc = 0; cyc < 300; cyc++) begin
      mem_addr_ok = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0; inv_all = 1'b0;
      #1;
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        timedOut = 1'b0;
        break;
      end
      stalls++;
      if (!accepted) begin
        if (mem_req) begin
          if (reqCycles == 0) begin
            reqAddr = mem_addr;
            reqLen  = mem_len;
          end else if (mem_addr !== reqAddr) begin
            addrStable = 1'b0;
          end
          reqCycles++;
          if (reqCycles > okDelay) begin
            mem_addr_ok = 1'b1;
            accepted = 1'b1;
          end
        end
      end else if (beat <= int'(reqLen)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memData(reqAddr + 32'(4 * beat));
        mem_rlast  = (beat == int'(reqLen));
        inv_all    = invAtLast && !unc && (beat == int'(reqLen));
        beat++;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cpu_en = 1'b0; cpu_uncached = 1'b0;
    mem_addr_ok = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0; inv_all = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %0b want 0", cpu_stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %0b want 0", mem_req); end
    total++; if (mem_addr !== 32'h0 || mem_len !== 8'h0) begin bad++; $display("[TB] FAIL reset_addr_len: got %h/%h want 0/0", mem_addr, mem_len); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    total++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL idle_outputs: got stall=%0b rdata=%h want 0/0", cpu_stall, cpu_rdata); end
  endtask

  task automatic test_cold_miss();
    int st, rc, es; logic [31:0] rd, ra, ed, ea; logic [7:0] rl, el; bit stable, to, em;
    modelFetch(32'h1FC0_0000, 1'b0, 0, 1'b0, es, ed, ea, el, em);
    applyStimulus(32'h1FC0_0000, 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != 6) begin bad++; $display("[TB] FAIL cold_stall: got %0d (timeout=%0b) want 6", st, to); end
    total++; if (rd !== 32'h11) begin bad++; $display("[TB] FAIL cold_rdata: got %h want 00000011", rd); end
    total++; if (ra !== 32'h1FC0_0000 || rl !== 8'd3) begin bad++; $display("[TB] FAIL cold_req: got %h/%0d want 1fc00000/3", ra, rl); end
    modelFetch(32'h1FC0_0008, 1'b0, 0, 1'b0, es, ed, ea, el, em);
    applyStimulus(32'h1FC0_0008, 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != 0) begin bad++; $display("[TB] FAIL warm_stall: got %0d want 0", st); end
    total++; if (rd !== 32'h33) begin bad++; $display("[TB] FAIL warm_rdata: got %h want 00000033", rd); end
  endtask

  task automatic test_conflict();
    int st, rc, es; logic [31:0] rd, ra, ed, ea; logic [7:0] rl, el; bit stable, to, em;
    logic [31:0] seq [3];
    seq[0] = 32'h0000_0010; seq[1] = 32'h0000_0810; seq[2] = 32'h0000_0010;
    for (int k = 0; k < 3; k++) begin
      modelFetch(seq[k], 1'b0, 0, 1'b0, es, ed, ea, el, em);
      applyStimulus(seq[k], 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
      total++; if (to || st != MISS_STALL) begin bad++; $display("[TB] FAIL conflict_stall[%0d]: got %0d want %0d", k, st, MISS_STALL); end
      total++; if (rd !== ed) begin bad++; $display("[TB] FAIL conflict_rdata[%0d]: got %h want %h", k, rd, ed); end
    end
  endtask

  task automatic test_uncached();
    int st, rc, es; logic [31:0] rd, ra, ed, ea; logic [7:0] rl, el; bit stable, to, em;
    for (int k = 0; k < 2; k++) begin
      modelFetch(32'hBFC0_0004, 1'b1, 0, 1'b0, es, ed, ea, el, em);
      applyStimulus(32'hBFC0_0004, 1'b1, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
      total++; if (to || st != 3) begin bad++; $display("[TB] FAIL unc_stall[%0d]: got %0d want 3", k, st); end
      total++; if (ra !== 32'hBFC0_0004 || rl !== 8'd0) begin bad++; $display("[TB] FAIL unc_req[%0d]: got %h/%0d want bfc00004/0", k, ra, rl); end
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL unc_rdata[%0d]: got %h want deadbeef", k, rd); end
    end
  endtask

  task automatic test_addr_ok_delay();
    int st, rc, es; logic [31:0] rd, ra, ed, ea; logic [7:0] rl, el; bit stable, to, em;
    modelFetch(32'h0000_2044, 1'b0, 5, 1'b0, es, ed, ea, el, em);
    applyStimulus(32'h0000_2044, 1'b0, 5, 1'b0, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != MISS_STALL + 5) begin bad++; $display("[TB] FAIL delay_stall: got %0d want %0d", st, MISS_STALL + 5); end
    total++; if (rc != 6 || !stable) begin bad++; $display("[TB] FAIL delay_req_hold: got cycles=%0d stable=%0b want 6/1", rc, stable); end
    total++; if (ra !== 32'h0000_2040 || rd !== ed) begin bad++; $display("[TB] FAIL delay_data: got %h/%h want 00002040/%h", ra, rd, ed); end
  endtask

  task automatic test_inv_all();
    int st, rc, es; logic [31:0] rd, ra, ed, ea; logic [7:0] rl, el; bit stable, to, em;
    logic [31:0] seq [3];
    seq[0] = 32'h0000_3000; seq[1] = 32'h0000_3114; seq[2] = 32'h0000_3000;
    for (int k = 0; k < 3; k++) begin
      modelFetch(seq[k], 1'b0, 0, 1'b0, es, ed, ea, el, em);
      applyStimulus(seq[k], 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
      total++; if (to || st != es || rd !== ed) begin bad++; $display("[TB] FAIL warmup[%0d]: got stall=%0d rdata=%h want %0d/%h", k, st, rd, es, ed); end
    end
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'h0000_3000; cpu_uncached = 1'b0; inv_all = 1'b1;
    #1;
    total++; if (cpu_stall !== 1'b0 || cpu_rdata !== memData(32'h0000_3000)) begin bad++; $display("[TB] FAIL inv_cycle_hit: got stall=%0b rdata=%h want 0/%h", cpu_stall, cpu_rdata, memData(32'h0000_3000)); end
    @(negedge clk);
    cpu_en = 1'b0; inv_all = 1'b0;
    foreach (refValid[i]) refValid[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      modelFetch(seq[1 - k], 1'b0, 0, 1'b0, es, ed, ea, el, em);
      applyStimulus(seq[1 - k], 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
      total++; if (to || st != MISS_STALL) begin bad++; $display("[TB] FAIL after_inv[%0d]: got %0d want %0d", k, st, MISS_STALL); end
    end
    modelFetch(32'h0000_4020, 1'b0, 0, 1'b1, es, ed, ea, el, em);
    applyStimulus(32'h0000_4020, 1'b0, 0, 1'b1, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != MISS_STALL || rd !== ed) begin bad++; $display("[TB] FAIL inv_rlast_fill: got %0d/%h want %0d/%h", st, rd, MISS_STALL, ed); end
    modelFetch(32'h0000_402C, 1'b0, 0, 1'b0, es, ed, ea, el, em);
    applyStimulus(32'h0000_402C, 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != 0 || rd !== ed) begin bad++; $display("[TB] FAIL inv_rlast_kept: got %0d/%h want 0/%h", st, rd, ed); end
    modelFetch(32'h0000_3114, 1'b0, 0, 1'b0, es, ed, ea, el, em);
    applyStimulus(32'h0000_3114, 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != MISS_STALL) begin bad++; $display("[TB] FAIL inv_rlast_others: got %0d want %0d", st, MISS_STALL); end
  endtask

  task automatic test_reset_mid_refill();
    int st, rc, es; logic [31:0] rd, ra, ed, ea; logic [7:0] rl, el; bit stable, to, em;
    logic [31:0] a;
    a = 32'h0000_5038;
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = a; cpu_uncached = 1'b0;
    @(negedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5030) begin bad++; $display("[TB] FAIL rmr_req: got %0b/%h want 1/00005030", mem_req, mem_addr); end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_rvalid = 1'b1; mem_rdata = memData(32'h0000_5030);
    @(negedge clk);
    mem_rdata = memData(32'h0000_5034);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("[TB] FAIL rmr_in_refill: got %0b want 1", cpu_stall); end
    rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL rmr_reset: got req=%0b stall=%0b want 0/0", mem_req, cpu_stall); end
    @(negedge clk); cpu_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    foreach (refValid[i]) refValid[i] = 1'b0;
    modelFetch(a, 1'b0, 0, 1'b0, es, ed, ea, el, em);
    applyStimulus(a, 1'b0, 0, 1'b0, st, rd, ra, rl, rc, stable, to);
    total++; if (to || st != MISS_STALL || rd !== ed) begin bad++; $display("[TB] FAIL rmr_refetch: got %0d/%h want %0d/%h", st, rd, MISS_STALL, ed); end
  endtask

  task automatic test_random();
    int st, rc, es, okDelay; logic [31:0] rd, ra, ed, ea, a; logic [7:0] rl, el; bit stable, to, em, unc, inv;
    for (int n = 0; n < 80; n++) begin
      a = 32'h0010_0000 | (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 7)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      unc = ($urandom_range(0, 9) == 0);
      if (unc) a = a | 32'hA000_0000;
      okDelay = $urandom_range(0, 3);
      inv = ($urandom_range(0, 15) == 0);
      modelFetch(a, unc, okDelay, inv, es, ed, ea, el, em);
      applyStimulus(a, unc, okDelay, inv, st, rd, ra, rl, rc, stable, to);
      total++; if (to || st != es) begin bad++; $display("[TB] FAIL rand_stall[%0d] addr=%h: got %0d want %0d", n, a, st, es); end
      total++; if (rd !== ed) begin bad++; $display("[TB] FAIL rand_rdata[%0d] addr=%h: got %h want %h", n, a, rd, ed); end
      if (em) begin
        total++; if (ra !== ea || rl !== el) begin bad++; $display("[TB] FAIL rand_req[%0d]: got %h/%0d want %h/%0d", n, ra, rl, ea, el); end
      end
    end
  endtask

  initial begin
    foreach (refValid[i]) begin
      refValid[i] = 1'b0;
      refTag[i]   = 0;
    end
    test_reset();
    test_cold_miss();
    test_conflict();
    test_uncached();
    test_addr_ok_delay();
    test_inv_all();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
